// File: rtl/wall_collision_checker.sv
// wall_collision_checker: judges a one-tile sprite move by scanning the wall ROM
// row by row over the destination footprint, reporting blocked/clear and the resulting position.
module wall_collision_checker #(
  parameter int MAP_W = 80,
  parameter int MAP_H = 26,
  parameter int SPRITE_W = 4,
  parameter int SPRITE_H = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       req_x,
  input  logic [4:0]       req_y,
  input  logic [1:0]       req_dir,
  output logic [4:0]       rom_addr,
  input  logic [MAP_W-1:0] rom_data,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_blocked,
  output logic [6:0]       resp_x,
  output logic [4:0]       resp_y
);
  localparam int RW = $clog2(SPRITE_H + 1);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state;
  logic [6:0] x_q, tx_q;
  logic [4:0] y_q, ty_q;
  logic [RW-1:0] r;
  logic signed [7:0] ntx;
  logic signed [5:0] nty;
  logic oob, hit;
  logic [MAP_W-1:0] win;
  // one bit wider and signed so stepping off column/row 0 yields -1
  assign ntx = $signed({1'b0, req_x}) + (req_dir == 2'd3 ? 8'sd1 : req_dir == 2'd2 ? -8'sd1 : 8'sd0);
  assign nty = $signed({1'b0, req_y}) + (req_dir == 2'd1 ? 6'sd1 : req_dir == 2'd0 ? -6'sd1 : 6'sd0);
  assign oob = ntx < 0 || nty < 0 || int'(ntx) + SPRITE_W > MAP_W || int'(nty) + SPRITE_H > MAP_H;
  // leftmost column is the MSB, so shifting left by tx puts the footprint at the top
  assign win = rom_data << tx_q;
  assign hit = |win[MAP_W-1 -: SPRITE_W];
  assign rom_addr = ty_q + 5'(r);
  assign req_ready = state == IDLE && !Reset;
  always_ff @(posedge Clk)
    if (Reset) begin
      state <= IDLE;
      r <= '0;
      x_q <= '0;
      y_q <= '0;
      tx_q <= '0;
      ty_q <= '0;
      resp_valid <= 1'b0;
      resp_blocked <= 1'b0;
      resp_x <= '0;
      resp_y <= '0;
    end else
      case (state)
        IDLE: if (req_valid) begin
          x_q <= req_x;
          y_q <= req_y;
          if (oob) begin
            state <= DONE;
            resp_valid <= 1'b1;
            resp_blocked <= 1'b1;
            resp_x <= req_x;
            resp_y <= req_y;
          end else begin
            state <= SCAN;
            tx_q <= ntx[6:0];
            ty_q <= nty[4:0];
            r <= '0;
          end
        end
        SCAN: if (hit || r == RW'(SPRITE_H - 1)) begin
          state <= DONE;
          resp_valid <= 1'b1;
          resp_blocked <= hit;
          resp_x <= hit ? x_q : tx_q;
          resp_y <= hit ? y_q : ty_q;
        end else r <= r + 1'b1;
        DONE: if (resp_ready) begin
          state <= IDLE;
          resp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_wall_collision_checker.sv
// tb_wall_collision_checker: directed vector table on the maze map plus randomized
// requests on random maps, checked against a cell-level legality model.
module tb_wall_collision_checker;
  localparam int MW = 80, MH = 26, SW = 4, SH = 4;
  logic Clk = 0, Reset = 1, req_valid = 0, resp_ready = 0;
  logic req_ready, resp_valid, resp_blocked;
  logic [6:0] req_x = 0, resp_x;
  logic [4:0] req_y = 0, resp_y, rom_addr;
  logic [1:0] req_dir = 0;
  logic [MW-1:0] rom_data;
  bit cells [MH][MW];
  int checks = 0, errors = 0;

  wall_collision_checker #(.MAP_W(MW), .MAP_H(MH), .SPRITE_W(SW), .SPRITE_H(SH)) dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_dir(req_dir), .rom_addr(rom_addr), .rom_data(rom_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_blocked(resp_blocked),
    .resp_x(resp_x), .resp_y(resp_y));

  always #5 Clk = ~Clk;

  always_comb begin
    rom_data = '0;
    for (int c = 0; c < MW; c++)
      if (int'(rom_addr) < MH) rom_data[MW-1-c] = cells[rom_addr][c];
  end

  typedef struct {int x; int y; int dir; bit blk; int rx; int ry; int lat;} vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic maze_map();
    for (int r = 0; r < MH; r++)
      for (int c = 0; c < MW; c++) cells[r][c] = r >= 22 || c < 4 || c >= 76;
  endtask

  function automatic void model(input int x, y, dir, output bit b, output int rx, ry, lat);
    int tx = x, ty = y;
    if (dir == 0) ty--; else if (dir == 1) ty++; else if (dir == 2) tx--; else tx++;
    b = 1; rx = x; ry = y;
    if (tx < 0 || ty < 0 || tx + SW > MW || ty + SH > MH) begin lat = 1; return; end
    for (int r = 0; r < SH; r++)
      for (int c = 0; c < SW; c++)
        if (cells[ty+r][tx+c]) begin lat = r + 2; return; end
    b = 0; rx = tx; ry = ty; lat = SH + 1;
  endfunction

  task automatic run(input int x, y, dir, input bit eb, input int ex, ey, el, hold);
    int n, ty, prev;
    bit got;
    bit [6:0] hx;
    bit [4:0] hy;
    ty = y + (dir == 1 ? 1 : 0) - (dir == 0 ? 1 : 0);
    @(negedge Clk);
    for (n = 0; n < 50 && !req_ready; n++) @(negedge Clk);
    chk("ready_before_req", int'(req_ready), 1);
    prev = int'(rom_addr);
    req_valid = 1; req_x = 7'(x); req_y = 5'(y); req_dir = 2'(dir);
    resp_ready = hold == 0;
    @(posedge Clk);
    #1 req_valid = 0; req_x = 7'($urandom); req_y = 5'($urandom); req_dir = 2'($urandom);
    got = 0;
    for (n = 1; n <= 20; n++) begin
      @(negedge Clk);
      if (resp_valid) begin got = 1; break; end
      chk("ready_busy", int'(req_ready), 0);
      if (n < el) chk("rom_addr_scan", int'(rom_addr), ty + n - 1);
    end
    chk("resp_seen", int'(got), 1);
    chk("latency", n, el);
    chk("blocked", int'(resp_blocked), int'(eb));
    chk("resp_x", int'(resp_x), ex);
    chk("resp_y", int'(resp_y), ey);
    if (el == 1) chk("rom_addr_oob_hold", int'(rom_addr), prev);
    hx = resp_x; hy = resp_y;
    for (int i = 0; i < hold; i++) begin
      req_valid = i == 0;
      @(negedge Clk);
      chk("hold_valid", int'(resp_valid), 1);
      chk("hold_blocked", int'(resp_blocked), int'(eb));
      chk("hold_x", int'(resp_x), int'(hx));
      chk("hold_y", int'(resp_y), int'(hy));
      chk("hold_ready", int'(req_ready), 0);
    end
    req_valid = 0;
    resp_ready = 1;
    @(negedge Clk);
    chk("valid_drop", int'(resp_valid), 0);
    chk("ready_after", int'(req_ready), 1);
  endtask

  initial begin
    vec_t tbl[$];
    bit b;
    int rx, ry, lat;
    maze_map();
    tbl = '{
      '{10, 0, 0, 1'b1, 10, 0, 1},
      '{10, 5, 3, 1'b0, 11, 5, 5},
      '{4, 5, 2, 1'b1, 4, 5, 2},
      '{10, 18, 1, 1'b1, 10, 18, 5},
      '{70, 5, 3, 1'b0, 71, 5, 5},
      '{76, 5, 3, 1'b1, 76, 5, 1},
      '{0, 5, 2, 1'b1, 0, 5, 1},
      '{10, 22, 1, 1'b1, 10, 22, 1},
      '{10, 21, 0, 1'b1, 10, 21, 4},
      '{72, 5, 3, 1'b1, 72, 5, 2},
      '{10, 6, 0, 1'b0, 10, 5, 5},
      '{4, 1, 0, 1'b0, 4, 0, 5}
    };
    repeat (2) @(negedge Clk);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_valid", int'(resp_valid), 0);
    chk("rst_blocked", int'(resp_blocked), 0);
    chk("rst_x", int'(resp_x), 0);
    chk("rst_y", int'(resp_y), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    Reset = 0;
    @(negedge Clk);
    chk("ready_after_rst", int'(req_ready), 1);
    foreach (tbl[i]) run(tbl[i].x, tbl[i].y, tbl[i].dir, tbl[i].blk, tbl[i].rx, tbl[i].ry, tbl[i].lat, 0);
    run(10, 5, 3, 1'b0, 11, 5, 5, 10);
    run(4, 5, 2, 1'b1, 4, 5, 2, 10);
    // reset during cycle 2 of a clear scan
    @(negedge Clk);
    req_valid = 1; req_x = 10; req_y = 5; req_dir = 3; resp_ready = 1;
    @(posedge Clk);
    #1 req_valid = 0;
    repeat (2) @(negedge Clk);
    Reset = 1;
    #1 chk("rst_mid_ready", int'(req_ready), 0);
    @(negedge Clk);
    chk("rst_mid_valid", int'(resp_valid), 0);
    chk("rst_mid_blocked", int'(resp_blocked), 0);
    chk("rst_mid_x", int'(resp_x), 0);
    chk("rst_mid_y", int'(resp_y), 0);
    chk("rst_mid_rom_addr", int'(rom_addr), 0);
    Reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("rst_mid_no_resp", int'(resp_valid), 0);
      chk("rst_mid_ready_after", int'(req_ready), 1);
    end
    run(10, 5, 3, 1'b0, 11, 5, 5, 0);
    for (int m = 0; m < 4; m++) begin
      for (int r = 0; r < MH; r++)
        for (int c = 0; c < MW; c++) cells[r][c] = $urandom_range(0, 39) == 0;
      for (int t = 0; t < 40; t++) begin
        int x = $urandom_range(0, MW - 1), y = $urandom_range(0, MH - 1), d = $urandom_range(0, 3);
        if ($urandom_range(0, 1) == 0) begin
          x = $urandom_range(0, MW - SW);
          y = $urandom_range(0, MH - SH);
        end
        model(x, y, d, b, rx, ry, lat);
        run(x, y, d, b, rx, ry, lat, $urandom_range(0, 4) == 0 ? $urandom_range(1, 3) : 0);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, errors %0d", errors);
    $fatal(1);
  end
endmodule
